// File: rtl/stage2_eval_if.sv
// Trial-score handshake between the score source (master) and stage2_eval (slave).
interface stage2_eval_if;
  logic       trial_valid;
  logic [2:0] trial_score;
  logic       trial_ready;

  modport master (output trial_valid, output trial_score, input trial_ready);
  modport slave  (input trial_valid, input trial_score, output trial_ready);
endinterface

// File: rtl/stage2_eval.sv
// Stage-2 evaluator: gated by stage-1 pass, collects N_TRIAL scores and
// registers pass2 / bonus2 / luck3 for the combinational stage-3 judge.
//
// state   | meaning
// IDLE    | waiting for start; results held
// COLLECT | accepting scores; one extra cycle with ready low after the last one
// JUDGE   | results registered on the exiting edge
// DONE    | one-cycle done pulse
module stage2_eval #(
  parameter int unsigned N_TRIAL   = 4,
  parameter int unsigned PASS_TH   = 8,
  parameter logic [2:0]  LFSR_SEED = 3'b101
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          pass1,
  stage2_eval_if.slave  trial,
  output logic          busy,
  output logic          done,
  output logic          pass2,
  output logic [1:0]    bonus2,
  output logic [2:0]    luck3
);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_JUDGE, S_DONE} state_e;

  localparam logic [3:0] N_C = 4'(N_TRIAL);

  state_e     state_q, state_d;
  logic [5:0] sum_q, sum_d;
  logic [3:0] count_q, count_d;
  logic [1:0] perfect_q, perfect_d;
  logic       zero_q, zero_d;
  logic       pass1_l_q, pass1_l_d;
  logic       pass2_q, pass2_d;
  logic [1:0] bonus2_q, bonus2_d;
  logic [2:0] luck3_q, luck3_d;
  logic [2:0] lfsr_q, lfsr_d;
  logic       ready_c;
  logic       accept;
  logic       sum_ok;

  assign accept = trial.trial_valid & ready_c;
  assign sum_ok = (32'(sum_q) >= PASS_TH);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      sum_q     <= 6'd0;
      count_q   <= 4'd0;
      perfect_q <= 2'd0;
      zero_q    <= 1'b0;
      pass1_l_q <= 1'b0;
      pass2_q   <= 1'b0;
      bonus2_q  <= 2'd0;
      luck3_q   <= 3'd0;
      lfsr_q    <= LFSR_SEED;
    end else begin
      state_q   <= state_d;
      sum_q     <= sum_d;
      count_q   <= count_d;
      perfect_q <= perfect_d;
      zero_q    <= zero_d;
      pass1_l_q <= pass1_l_d;
      pass2_q   <= pass2_d;
      bonus2_q  <= bonus2_d;
      luck3_q   <= luck3_d;
      lfsr_q    <= lfsr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_COLLECT;
      S_COLLECT: if (count_q == N_C) state_d = S_JUDGE;
      S_JUDGE:   state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sum_d     = sum_q;
    count_d   = count_q;
    perfect_d = perfect_q;
    zero_d    = zero_q;
    pass1_l_d = pass1_l_q;
    pass2_d   = pass2_q;
    bonus2_d  = bonus2_q;
    luck3_d   = luck3_q;
    lfsr_d    = {lfsr_q[1:0], lfsr_q[2] ^ lfsr_q[1]};
    case (state_q)
      S_IDLE: begin
        if (start) begin
          pass1_l_d = pass1;
          sum_d     = 6'd0;
          count_d   = 4'd0;
          perfect_d = 2'd0;
          zero_d    = 1'b0;
          pass2_d   = 1'b0;
          bonus2_d  = 2'd0;
        end
      end
      S_COLLECT: begin
        if (accept) begin
          sum_d   = sum_q + {3'd0, trial.trial_score};
          count_d = count_q + 4'd1;
          if (trial.trial_score == 3'd7 && perfect_q != 2'd3) perfect_d = perfect_q + 2'd1;
          if (trial.trial_score == 3'd0) zero_d = 1'b1;
        end
      end
      S_JUDGE: begin
        pass2_d  = pass1_l_q & ~zero_q & sum_ok;
        bonus2_d = perfect_q;
        luck3_d  = lfsr_q;
      end
      default: ;
    endcase
  end

  // Ready stays low in the trailing COLLECT cycle once all scores are in.
  always_comb begin
    ready_c = (state_q == S_COLLECT) && (count_q != N_C);
    busy    = (state_q != S_IDLE);
    done    = (state_q == S_DONE);
  end

  assign trial.trial_ready = ready_c;
  assign pass2  = pass2_q;
  assign bonus2 = bonus2_q;
  assign luck3  = luck3_q;

endmodule

// File: tb/tb_stage2_eval.sv
// Directed, table-driven bench for stage2_eval with hand-sequenced corner cases.
module tb_stage2_eval;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       pass1;
  logic       busy, done, pass2;
  logic [1:0] bonus2;
  logic [2:0] luck3;
  logic [2:0] m_lfsr;

  int checks = 0;
  int errors = 0;

  stage2_eval_if tif ();

  stage2_eval dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .pass1  (pass1),
    .trial  (tif.slave),
    .busy   (busy),
    .done   (done),
    .pass2  (pass2),
    .bonus2 (bonus2),
    .luck3  (luck3)
  );

  always #5 clk = ~clk;

  // Reference LFSR: seed in reset, {q[1:0], q2^q1} otherwise.
  always @(posedge clk) begin
    if (!rst_n) m_lfsr <= 3'b101;
    else        m_lfsr <= {m_lfsr[1:0], m_lfsr[2] ^ m_lfsr[1]};
  end

  typedef struct {
    logic             pass1;
    logic [3:0][2:0]  sc;
    logic             exp_pass2;
    logic [1:0]       exp_bonus2;
  } vec_t;

  vec_t vecs[8];

  function automatic vec_t mk(input logic p1, input logic [2:0] a, input logic [2:0] b,
                              input logic [2:0] c, input logic [2:0] d,
                              input logic ep, input logic [1:0] eb);
    vec_t v;
    v.pass1 = p1;
    v.sc[0] = a; v.sc[1] = b; v.sc[2] = c; v.sc[3] = d;
    v.exp_pass2 = ep;
    v.exp_bonus2 = eb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge; start is sampled at the next posedge (edge 0).
  task automatic run_vec(input vec_t v, input logic use_const, input logic [2:0] const_luck);
    logic [2:0] exp_luck;
    start = 1'b1;
    pass1 = v.pass1;
    tif.trial_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("collect_busy", 8'(busy), 8'd1);
    chk("collect_ready", 8'(tif.trial_ready), 8'd1);
    chk("start_clears_pass2", 8'(pass2), 8'd0);
    chk("start_clears_bonus2", 8'(bonus2), 8'd0);
    tif.trial_valid = 1'b1;
    tif.trial_score = v.sc[0];
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      tif.trial_score = v.sc[i];
    end
    @(negedge clk);
    tif.trial_valid = 1'b0;
    chk("ready_drop", 8'(tif.trial_ready), 8'd0);
    chk("no_early_done", 8'(done), 8'd0);
    @(negedge clk);
    exp_luck = use_const ? const_luck : m_lfsr;
    chk("judge_no_done", 8'(done), 8'd0);
    chk("judge_busy", 8'(busy), 8'd1);
    @(negedge clk);
    chk("done_pulse", 8'(done), 8'd1);
    chk("done_busy", 8'(busy), 8'd1);
    chk("pass2", 8'(pass2), 8'(v.exp_pass2));
    chk("bonus2", 8'(bonus2), 8'(v.exp_bonus2));
    chk("luck3", 8'(luck3), 8'(exp_luck));
    @(negedge clk);
    chk("done_falls", 8'(done), 8'd0);
    chk("idle_busy", 8'(busy), 8'd0);
    chk("pass2_held", 8'(pass2), 8'(v.exp_pass2));
    chk("luck3_held", 8'(luck3), 8'(exp_luck));
  endtask

  initial begin
    logic       gv[7];
    logic [2:0] gs[7];
    logic       gst[7];
    logic [2:0] exp_luck;
    logic [2:0] prev_luck;

    vecs[0] = mk(1'b1, 3'd2, 3'd2, 3'd2, 3'd2, 1'b1, 2'd0);
    vecs[1] = mk(1'b1, 3'd7, 3'd7, 3'd7, 3'd7, 1'b1, 2'd3);
    vecs[2] = mk(1'b1, 3'd7, 3'd7, 3'd7, 3'd0, 1'b0, 2'd3);
    vecs[3] = mk(1'b0, 3'd5, 3'd5, 3'd5, 3'd5, 1'b0, 2'd0);
    vecs[4] = mk(1'b1, 3'd3, 3'd3, 3'd1, 3'd1, 1'b1, 2'd0);
    vecs[5] = mk(1'b1, 3'd1, 3'd2, 3'd2, 3'd2, 1'b0, 2'd0);
    vecs[6] = mk(1'b1, 3'd0, 3'd7, 3'd7, 3'd7, 1'b0, 2'd3);
    vecs[7] = mk(1'b1, 3'd7, 3'd1, 3'd1, 3'd1, 1'b1, 2'd1);

    // Reset held with start and valid asserted.
    rst_n = 1'b0;
    start = 1'b1;
    pass1 = 1'b1;
    tif.trial_valid = 1'b1;
    tif.trial_score = 3'd7;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_ready", 8'(tif.trial_ready), 8'd0);
    chk("rst_done", 8'(done), 8'd0);
    chk("rst_pass2", 8'(pass2), 8'd0);
    chk("rst_bonus2", 8'(bonus2), 8'd0);
    chk("rst_luck3", 8'(luck3), 8'd0);
    rst_n = 1'b1;

    // LFSR from reset: 011,111,110,100,001,010 -> JUDGE sees 010.
    run_vec(vecs[0], 1'b1, 3'b010);
    for (int k = 1; k < 8; k++) run_vec(vecs[k], 1'b0, 3'd0);

    // Gapped handshake with stray start (pass1=0) pulses during COLLECT.
    gv  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    gs  = '{3'd3, 3'd7, 3'd7, 3'd1, 3'd2, 3'd0, 3'd3};
    gst = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    start = 1'b1;
    pass1 = 1'b1;
    @(negedge clk);
    pass1 = 1'b0;
    for (int i = 0; i < 7; i++) begin
      start = gst[i];
      tif.trial_valid = gv[i];
      tif.trial_score = gs[i];
      @(negedge clk);
      chk("gap_busy", 8'(busy), 8'd1);
    end
    start = 1'b0;
    tif.trial_valid = 1'b1;
    tif.trial_score = 3'd0;
    chk("gap_ready_drop", 8'(tif.trial_ready), 8'd0);
    @(negedge clk);
    tif.trial_valid = 1'b0;
    exp_luck = m_lfsr;
    chk("gap_no_done", 8'(done), 8'd0);
    @(negedge clk);
    chk("gap_done", 8'(done), 8'd1);
    chk("gap_pass2", 8'(pass2), 8'd1);
    chk("gap_bonus2", 8'(bonus2), 8'd0);
    chk("gap_luck3", 8'(luck3), 8'(exp_luck));
    @(negedge clk);
    chk("gap_idle", 8'(busy), 8'd0);
    prev_luck = luck3;

    // start with valid high in IDLE then mid-run reset after two scores.
    start = 1'b1;
    pass1 = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tif.trial_valid = 1'b1;
    tif.trial_score = 3'd7;
    @(negedge clk);
    @(negedge clk);
    chk("mid_busy", 8'(busy), 8'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_busy", 8'(busy), 8'd0);
    chk("mid_rst_ready", 8'(tif.trial_ready), 8'd0);
    chk("mid_rst_pass2", 8'(pass2), 8'd0);
    chk("mid_rst_luck3", 8'(luck3), 8'd0);
    chk("mid_prev_luck_nonzero", 8'(prev_luck == 3'd0), 8'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("mid_no_done", 8'(done), 8'd0);
      chk("mid_stays_idle", 8'(busy), 8'd0);
    end
    tif.trial_valid = 1'b0;
    run_vec(vecs[1], 1'b0, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
